// File: rtl/gemm_result_writer_if.sv
// Result-stream and memory-write-port bundle for the GEMM result writer.
// The slave modport is the writer's view; the master modport is the producer and memory side.
interface gemm_result_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;

    modport slave (
        input  in_valid, in_data, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/gemm_result_writer.sv
// Writes a row-major N x N product stream to memory at base_addr onward,
// reporting done, a wrapping checksum and a framing error on in_last.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; input stream not accepted
// S_RUN   | accepting elements, one per cycle when memory keeps up
// S_FLUSH | all N*N elements taken; waiting for the final write to land
module gemm_result_writer #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MATRIX_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    gemm_result_writer_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  err_last
);
    localparam int CW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  start_acc;
    logic                  in_acc;
    logic                  out_acc;
    logic                  last_elem;

    // done is high in the first IDLE cycle; a start there is still ignored
    assign start_acc = (state == S_IDLE) && start && !done;
    assign in_acc    = bus.in_valid && bus.in_ready;
    assign out_acc   = bus.mem_we && bus.mem_ready;
    assign last_elem = (row == LAST_IDX) && (col == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (in_acc && last_elem) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_acc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        case (state)
            S_RUN: begin
                bus.in_ready = !bus.mem_we || bus.mem_ready;
                busy         = 1'b1;
            end
            S_FLUSH: begin
                busy = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
                busy         = 1'b0;
            end
        endcase
    end

    // Row-major order makes base + row*N + col a plain running increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            addr_nxt <= '0;
            checksum <= '0;
            err_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == S_FLUSH) && out_acc;
            if (start_acc) begin
                row      <= '0;
                col      <= '0;
                addr_nxt <= base_addr;
                checksum <= '0;
                err_last <= 1'b0;
            end else if (in_acc) begin
                addr_nxt <= addr_nxt + ADDR_WIDTH'(1);
                checksum <= checksum + bus.in_data;
                if (bus.in_last != last_elem) begin
                    err_last <= 1'b1;
                end
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Output register reloads on the same cycle the held write drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (in_acc) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_nxt;
            bus.mem_wdata <= bus.in_data;
        end else if (out_acc) begin
            bus.mem_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed and randomized jobs for gemm_result_writer at N=4, checked against
// an expected write list, checksum and framing result built from the job description.
module tb_gemm_result_writer;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int N  = 4;
    localparam int NE = N * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic          err_last;

    gemm_result_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    gemm_result_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(N)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .bus(bus.slave),
        .busy(busy),
        .done(done),
        .checksum(checksum),
        .err_last(err_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int writes = 0;
    int done_cnt = 0;
    int gaps = 0;
    int prev_wr = -10;
    int mr_mode = 0;
    int stall_cnt = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] jd[NE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Memory side: always ready, random, or three stall cycles on the element holding 6
    always @(posedge clk) begin
        #1;
        case (mr_mode)
            1: bus.mem_ready = 1'($urandom_range(0, 1));
            2: begin
                if (bus.mem_we && bus.mem_wdata == 16'd6 && stall_cnt < 3) begin
                    bus.mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end
            default: bus.mem_ready = 1'b1;
        endcase
    end

    // Write monitor: a handshake seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (!reset && bus.mem_we && bus.mem_ready) begin
            check("write_expected", 32'(exp_addr_q.size() > 0), 32'd1);
            if (exp_addr_q.size() > 0) begin
                check("wr_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
                check("wr_data", 32'(bus.mem_wdata), 32'(exp_data_q.pop_front()));
            end
            writes++;
            if (cycle - prev_wr != 1) gaps++;
            prev_wr = cycle;
        end
        if (mr_mode == 2 && bus.mem_we && !bus.mem_ready) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_addr", 32'(bus.mem_addr), 32'h0105);
            check("stall_data", 32'(bus.mem_wdata), 32'd6);
        end
        if (done) done_cnt++;
    end

    task automatic run_job(input logic [AW-1:0] base, input int last_pos, input bit with_gaps,
                           input bit start_mid, input int abort_after);
        int  sum;
        int  i;
        int  n_send;
        int  w0;
        int  d0;
        bit  acc;
        bit  exp_err;
        exp_addr_q.delete();
        exp_data_q.delete();
        sum = 0;
        for (int k = 0; k < NE; k++) begin
            exp_addr_q.push_back(base + AW'(k));
            exp_data_q.push_back(jd[k]);
            sum += int'(jd[k]);
        end
        exp_err = (last_pos != NE - 1);
        n_send  = (abort_after >= 0) ? abort_after : NE;
        w0 = writes;
        d0 = done_cnt;

        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared_on_start", 32'(err_last), 32'd0);
        check("sum_cleared_on_start", 32'(checksum), 32'd0);

        i = 0;
        for (int budget = 0; budget < 400 && i < n_send; budget++) begin
            bus.in_valid = with_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data  = jd[i];
            bus.in_last  = (i == last_pos);
            start        = start_mid && (i == 8);
            if (start) base_addr = 16'hAAAA;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        check("elements_accepted", 32'(i), 32'(n_send));
        if (abort_after >= 0) return;

        for (int b = 0; b < 300 && !done; b++) begin
            @(posedge clk); #1;
        end
        check("done_seen", 32'(done), 32'd1);
        check("checksum", 32'(checksum), 32'(sum & 32'hFFFF));
        check("err_last", 32'(err_last), 32'(exp_err));
        check("idle_not_busy", 32'(busy), 32'd0);
        check("mem_we_dropped", 32'(bus.mem_we), 32'd0);
        check("write_count", 32'(writes - w0), 32'(NE));
        check("queue_drained", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("err_sticky_after_done", 32'(err_last), 32'(exp_err));
        check("checksum_stable", 32'(checksum), 32'(sum & 32'hFFFF));
    endtask

    initial begin
        int g0;
        int w0;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_err_last", 32'(err_last), 32'd0);
        reset = 1'b0;

        // Streaming job at full rate
        for (int k = 0; k < NE; k++) jd[k] = DW'(k + 1);
        g0 = gaps;
        run_job(16'h0100, NE - 1, 1'b0, 1'b0, -1);
        check("full_rate_no_gaps", 32'(gaps - g0), 32'd1);

        // Memory stalls three cycles while element 6 is pending
        mr_mode = 2;
        run_job(16'h0100, NE - 1, 1'b0, 1'b0, -1);
        check("stall_cycles", 32'(stall_cnt), 32'd3);
        mr_mode = 0;

        // Address wrap past the top of the address space
        for (int k = 0; k < NE; k++) jd[k] = DW'($urandom);
        run_job(16'hFFF8, NE - 1, 1'b0, 1'b0, -1);

        // in_last on element 5 and missing on element 16
        for (int k = 0; k < NE; k++) jd[k] = DW'(k + 1);
        run_job(16'h0400, 4, 1'b0, 1'b0, -1);

        // All-ones data with a stray start mid-job
        for (int k = 0; k < NE; k++) jd[k] = 16'hFFFF;
        run_job(16'h0500, NE - 1, 1'b0, 1'b1, -1);
        check("checksum_all_ones", 32'(checksum), 32'hFFF0);

        // Abort after seven elements, then restart at a new base
        for (int k = 0; k < NE; k++) jd[k] = DW'($urandom);
        run_job(16'h0300, NE - 1, 1'b0, 1'b0, 7);
        reset = 1'b1;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_checksum", 32'(checksum), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < NE; k++) jd[k] = DW'($urandom);
        run_job(16'h0200, NE - 1, 1'b0, 1'b0, -1);

        // Random data, bases, framing, input gaps and memory backpressure
        mr_mode = 1;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < NE; k++) jd[k] = DW'($urandom);
            run_job(AW'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NE - 1)) : NE - 1,
                    1'b1, 1'b0, -1);
        end
        mr_mode = 0;

        // Input offered while idle must be ignored
        w0 = writes;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        check("idle_no_writes", 32'(writes - w0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
